// File: rtl/clk_seq_pkg.sv
// clk_seq_pkg: shared types and sizing helpers for the clock-group reset sequencer
package clk_seq_pkg;
  typedef enum logic [1:0] {OP_RESTART, OP_POWER_DOWN, OP_POWER_UP, OP_RSVD} op_e;
  typedef enum logic [2:0] {BOOT_SETTLE, BOOT_HOLD, IDLE, SETTLE, HOLD_REL, HOLD_DOWN, RESP} state_e;
  function automatic int tmr_w(input int s, input int h);
    return $clog2((s > h ? s : h) + 1);
  endfunction
  localparam int TMR_W = tmr_w(8, 16);
endpackage

// File: rtl/clk_seq_timer.sv
// clk_seq_timer: loadable down-counter that parks at zero and flags it
module clk_seq_timer #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clock)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer: boots clock-group members in turn and serves per-member restart/power requests
module clock_group_reset_sequencer
  import clk_seq_pkg::*;
#(
  parameter int N_MEMBERS     = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int HOLD_CYCLES   = 16,
  parameter int IDX_W         = (N_MEMBERS > 1) ? $clog2(N_MEMBERS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [IDX_W-1:0]     req_member,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [N_MEMBERS-1:0] member_clock_en,
  output logic [N_MEMBERS-1:0] member_reset,
  output logic                 boot_done,
  output logic                 busy
);
  localparam int TW = tmr_w(SETTLE_CYCLES, HOLD_CYCLES);
  localparam logic [TW-1:0] SET_LD  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  state_e               state, state_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [N_MEMBERS-1:0] en_n, mr_n;
  logic                 done_n, rv_n, re_n, ld, zero, up, bad, last;
  logic [TW-1:0]        ld_val;
  assign bad  = 32'(req_member) >= N_MEMBERS;
  assign up   = !bad && member_clock_en[req_member];
  assign last = idx == IDX_W'(N_MEMBERS - 1);
  clk_seq_timer #(.W(TW)) u_tmr (
    .clock    (clock),
    .reset    (reset),
    .load     (ld),
    .load_val (ld_val),
    .zero     (zero)
  );
  always_comb begin
    state_n = state;
    idx_n   = idx;
    en_n    = member_clock_en;
    mr_n    = member_reset;
    done_n  = boot_done;
    rv_n    = 1'b0;
    re_n    = 1'b0;
    ld      = 1'b0;
    ld_val  = SET_LD;
    case (state)
      // Right after reset the current member's clock is still off: turn it on and start settling.
      BOOT_SETTLE:
        if (!member_clock_en[idx]) begin
          en_n[idx] = 1'b1;
          ld        = 1'b1;
        end else if (zero) begin
          state_n = BOOT_HOLD;
          ld      = 1'b1;
          ld_val  = HOLD_LD;
        end
      BOOT_HOLD:
        if (zero) begin
          mr_n[idx] = 1'b0;
          if (last) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n       = idx + 1'b1;
            en_n[idx_n] = 1'b1;
            state_n     = BOOT_SETTLE;
            ld          = 1'b1;
          end
        end
      IDLE:
        if (req_valid && req_ready) begin
          state_n = RESP;
          rv_n    = 1'b1;
          if (bad || req_op == OP_RSVD || (req_op == OP_RESTART && !up)) re_n = 1'b1;
          else if (req_op == OP_RESTART || (req_op == OP_POWER_DOWN && up) || (req_op == OP_POWER_UP && !up)) begin
            rv_n  = 1'b0;
            idx_n = req_member;
            ld    = 1'b1;
            if (req_op == OP_POWER_UP) begin
              en_n[req_member] = 1'b1;
              state_n          = SETTLE;
            end else begin
              mr_n[req_member] = 1'b1;
              ld_val           = HOLD_LD;
              state_n          = req_op == OP_RESTART ? HOLD_REL : HOLD_DOWN;
            end
          end
        end
      SETTLE:
        if (zero) begin
          state_n = HOLD_REL;
          ld      = 1'b1;
          ld_val  = HOLD_LD;
        end
      HOLD_REL:
        if (zero) begin
          mr_n[idx] = 1'b0;
          rv_n      = 1'b1;
          state_n   = RESP;
        end
      HOLD_DOWN:
        if (zero) begin
          en_n[idx] = 1'b0;
          rv_n      = 1'b1;
          state_n   = RESP;
        end
      RESP:    state_n = IDLE;
      default: state_n = BOOT_SETTLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state           <= BOOT_SETTLE;
      idx             <= '0;
      member_clock_en <= '0;
      member_reset    <= '1;
      boot_done       <= 1'b0;
      req_ready       <= 1'b0;
      busy            <= 1'b1;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      member_clock_en <= en_n;
      member_reset    <= mr_n;
      boot_done       <= done_n;
      req_ready       <= state_n == IDLE && done_n;
      busy            <= !(state_n == IDLE && done_n);
      resp_valid      <= rv_n;
      resp_err        <= re_n;
    end
endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// tb_clock_group_reset_sequencer: event-timeline model of the sequencer checked every cycle, plus literal timing pins
module tb_clock_group_reset_sequencer;
  localparam int N = 4;
  localparam int S = 8;
  localparam int H = 16;
  localparam int P = S + H;
  localparam int K_EN = 0, K_RST = 1, K_DONE = 2, K_RESP = 3, K_IDLE = 4;
  logic clock = 1'b0;
  logic reset, req_valid, req_ready, resp_valid, resp_err, boot_done, busy;
  logic [1:0] req_op, req_member;
  logic [N-1:0] member_clock_en, member_reset;
  clock_group_reset_sequencer #(.N_MEMBERS(N), .SETTLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_member      (req_member),
    .resp_valid      (resp_valid),
    .resp_err        (resp_err),
    .member_clock_en (member_clock_en),
    .member_reset    (member_reset),
    .boot_done       (boot_done),
    .busy            (busy)
  );
  always #5 clock = ~clock;
  int checks = 0, errors = 0, cyc = 0, resp_cnt = 0, exp_resp_cnt = 0;
  bit mv = 0;
  logic [N-1:0] exp_en, exp_rst;
  logic exp_done, exp_ready, exp_busy, exp_rv, exp_err;
  typedef struct {int t; int k; int m; logic v;} ev_t;
  ev_t q[$];
  function automatic void sched(input int t, input int k, input int m, input logic v);
    ev_t e;
    e.t = t; e.k = k; e.m = m; e.v = v;
    q.push_back(e);
  endfunction
  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask
  // Model: every output change is an event scheduled at an absolute cycle from the timing rules.
  initial forever begin
    @(posedge clock);
    cyc++;
    if (reset) begin
      exp_en = '0; exp_rst = '1; exp_done = 0; exp_ready = 0; exp_busy = 1; exp_rv = 0; exp_err = 0;
      q.delete();
      mv = 1;
      for (int i = 0; i < N; i++) begin
        sched(cyc + 1 + P * i, K_EN, i, 1);
        sched(cyc + 1 + P * (i + 1), K_RST, i, 0);
      end
      sched(cyc + 1 + P * N, K_DONE, 0, 0);
    end else begin
      if (req_valid && exp_ready) begin
        int t, m, r;
        logic u, e;
        t = cyc - 1; m = int'(req_member); u = exp_en[m]; e = 0; r = t + 1;
        if (req_op == 3 || m >= N || (req_op == 0 && !u)) e = 1;
        else if (req_op == 0) begin sched(t + 1, K_RST, m, 1); sched(t + 1 + H, K_RST, m, 0); r = t + 1 + H; end
        else if (req_op == 1 && u) begin sched(t + 1, K_RST, m, 1); sched(t + 1 + H, K_EN, m, 0); r = t + 1 + H; end
        else if (req_op == 2 && !u) begin sched(t + 1, K_EN, m, 1); sched(t + 1 + P, K_RST, m, 0); r = t + 1 + P; end
        sched(r, K_RESP, 0, e);
        sched(r + 1, K_IDLE, 0, 0);
        exp_ready = 0; exp_busy = 1;
      end
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].t == cyc) begin
          case (q[i].k)
            K_EN:   exp_en[q[i].m] = q[i].v;
            K_RST:  exp_rst[q[i].m] = q[i].v;
            K_DONE: begin exp_done = 1; exp_ready = 1; exp_busy = 0; end
            K_RESP: begin exp_rv = 1; exp_err = q[i].v; exp_resp_cnt++; end
            default: begin exp_rv = 0; exp_err = 0; exp_ready = 1; exp_busy = 0; end
          endcase
          q.delete(i);
        end
    end
  end
  initial forever begin
    @(negedge clock);
    if (mv) begin
      checks++;
      if ({member_clock_en, member_reset, boot_done, req_ready, busy, resp_valid, resp_err} !==
          {exp_en, exp_rst, exp_done, exp_ready, exp_busy, exp_rv, exp_err}) begin
        errors++;
        $display("FAIL outputs cyc=%0d got en=%b rst=%b done=%b rdy=%b busy=%b rv=%b err=%b expected en=%b rst=%b done=%b rdy=%b busy=%b rv=%b err=%b",
                 cyc, member_clock_en, member_reset, boot_done, req_ready, busy, resp_valid, resp_err,
                 exp_en, exp_rst, exp_done, exp_ready, exp_busy, exp_rv, exp_err);
      end
      checks++;
      if ((~member_reset & ~member_clock_en) !== '0) begin
        errors++;
        $display("FAIL invariant cyc=%0d got en=%b rst=%b, expected no released reset with gated clock", cyc, member_clock_en, member_reset);
      end
      if (resp_valid) resp_cnt++;
    end
  end
  task automatic do_req(input logic [1:0] op, input logic [1:0] m, output int lat, output logic err);
    int n;
    req_op = op; req_member = m; req_valid = 1;
    n = 0;
    while (!req_ready && n < 500) begin @(negedge clock); n++; end
    chk("accept_wait", req_ready, 1);
    @(negedge clock);
    req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 60) begin @(negedge clock); lat++; end
    err = resp_err;
    @(negedge clock);
  endtask
  task automatic check_boot(input int c0);
    int n;
    n = 0; while (!member_clock_en[0] && n < 300) begin @(negedge clock); n++; end
    chk("en0_rise", cyc - c0, 1);
    n = 0; while (member_reset[0] && n < 300) begin @(negedge clock); n++; end
    chk("rst0_fall", cyc - c0, 25);
    n = 0; while (!boot_done && n < 300) begin @(negedge clock); n++; end
    chk("boot_done", cyc - c0, 97);
    chk("ready_at_boot", req_ready, 1);
    chk("rst3_at_boot", member_reset[3], 0);
  endtask
  initial begin
    int c0, lat;
    logic err;
    reset = 1; req_valid = 0; req_op = 0; req_member = 0;
    repeat (2) @(negedge clock);
    c0 = cyc; reset = 0;
    req_valid = 1; req_op = 0; req_member = 2;
    check_boot(c0);
    do_req(2'd0, 2'd2, lat, err); chk("restart_lat", lat, 17); chk("restart_err", err, 0);
    do_req(2'd1, 2'd1, lat, err); chk("pdown_lat", lat, 17); chk("pdown_err", err, 0);
    chk("pdown_en1", member_clock_en[1], 0);
    do_req(2'd0, 2'd1, lat, err); chk("restart_down_lat", lat, 1); chk("restart_down_err", err, 1);
    do_req(2'd1, 2'd1, lat, err); chk("pdown_noop_lat", lat, 1); chk("pdown_noop_err", err, 0);
    do_req(2'd2, 2'd1, lat, err); chk("pup_lat", lat, 25); chk("pup_err", err, 0);
    do_req(2'd2, 2'd0, lat, err); chk("pup_noop_lat", lat, 1); chk("pup_noop_err", err, 0);
    do_req(2'd3, 2'd0, lat, err); chk("rsvd_lat", lat, 1); chk("rsvd_err", err, 1);
    do_req(2'd1, 2'd3, lat, err); chk("pdown3_lat", lat, 17);
    req_op = 2; req_member = 3; req_valid = 1;
    @(negedge clock);
    req_valid = 0;
    repeat (10) @(negedge clock);
    reset = 1;
    @(negedge clock);
    c0 = cyc; reset = 0;
    chk("rst_mid_en", member_clock_en, 0);
    chk("rst_mid_rst", member_reset, 15);
    chk("rst_mid_busy", busy, 1);
    chk("rst_mid_rv", resp_valid, 0);
    check_boot(c0);
    do_req(2'd0, 2'd0, lat, err); chk("restart0_lat", lat, 17); chk("restart0_err", err, 0);
    chk("resp_count", resp_cnt, exp_resp_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
